uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of `uart_top`. It captures each byte presented on `rx_data` when `rx_done` rises, and stores it in a circular FIFO. Consumers read bytes through a registered read handshake. Fill status and a sticky overflow flag are exported so slow consumers can detect dropped bytes.

## Interface
- `DEPTH_LOG2`, default 4; FIFO depth = 2^DEPTH_LOG2 entries (16); legal range 1..8.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte from `uart_top`; sampled in the cycle `rx_done` rises.
- `rx_done`  in  1  byte-complete indication from `uart_top`; may be a pulse or a level of any width ≥1 cycle.
- `rd_en`  in  1  read request from consumer.
- `rd_data`  out  8  byte popped by the last accepted read; holds its value until the next accepted read.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is new this cycle.
- `empty`  out  1  count == 0.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `count`  out  DEPTH_LOG2+1  number of stored bytes.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Write strobe `wr = rx_done & ~rx_done_q`, where `rx_done_q` is `rx_done` registered. Exactly one write is made per rising edge of `rx_done`, regardless of its width.
- Storage: 2^DEPTH_LOG2 × 8 array; `wr_ptr` and `rd_ptr` are each DEPTH_LOG2 bits and wrap modulo depth. `count` is tracked separately.
- Accepted write (`wr` and (not full, or accepted read in the same cycle)):
  - `mem[wr_ptr] <= rx_data`
  - `wr_ptr` increments.
- Accepted read (`rd_en` and not `empty`):
  - `rd_data <= mem[rd_ptr]`
  - `rd_ptr` increments
  - `rd_valid` = 1 next cycle.
- `rd_en` while `empty` is ignored: no pointer change, `rd_valid` = 0, `rd_data` holds.
- `count` update:
  - +1 on an accepted write alone.
  - −1 on an accepted read alone.
  - Unchanged when both a write and a read are accepted.
- Full with simultaneous `wr` and `rd_en`: both are accepted, `count` stays full, no overflow.
- Empty with simultaneous `wr` and `rd_en`: the read is ignored (evaluated against current empty state) and the write is accepted.
- Overflow: `wr` while full without an accepted read drops the byte and sets `overflow` = 1. FIFO contents and pointers are untouched.
- `ovf_clr` clears `overflow` next cycle. If `ovf_clr` and a new drop occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `rd_data` = 8'h00, `rd_valid` = 0, `empty` = 1, `full` = 0, `count` = 0, `overflow` = 0.
  - Pointers = 0.
  - `rx_done_q` = 1, so an `rx_done` held high across reset release does not create a write.
- Asserting `rst` mid-operation discards all stored bytes immediately (asynchronous); no partial state survives.
- Write latency:
  - `rx_done` rises in cycle N.
  - Byte stored at the clock edge ending cycle N.
  - `count`, `empty` and `full` reflect the write from cycle N+1.
- Read latency:
  - `rd_en` is accepted in cycle N.
  - `rd_data` and `rd_valid` are valid in cycle N+1.
  - `count` is decremented from cycle N+1.
- Back-to-back reads: `rd_en` held high drains one byte per cycle; `rd_valid` stays high for consecutive cycles until empty.
- Status outputs (`empty`, `full`, `count`) are registered or derived only from registered `count`; none is combinational from inputs.
- Write-to-read turnaround: a byte written in cycle N can be read with `rd_en` in cycle N+1, giving data in N+2.

## Test plan
- Reset then single byte: pulse `rx_done` for 1 cycle with `rx_data` = 8'h55 -> next cycle `count` = 1, `empty` = 0. Then `rd_en` for 1 cycle -> next cycle `rd_data` = 8'h55, `rd_valid` = 1, `empty` = 1.
- Wide `rx_done`: hold `rx_done` high for 10 cycles with 8'hA3 -> exactly one entry (`count` = 1). Raising it again with 8'h3C -> `count` = 2. Reads return A3 then 3C.
- Fill and overflow: write 8'h00..8'h0F -> `full` = 1, `count` = 16. Write 8'hFF -> `overflow` = 1, `count` = 16. Drain all 16 -> data 00..0F in order, 8'hFF absent, `overflow` stays 1 until a `ovf_clr` pulse, then 0.
- Wrap-around: write and read 40 sequential bytes (i+8'h10) interleaved so `count` stays ≤3 -> every read matches in order across two pointer wraps; `full` and `overflow` never assert.
- Simultaneous events:
  - Full with `wr` and `rd_en` in the same cycle -> `count` stays 16, no overflow, oldest byte returned.
  - Empty with both in the same cycle -> `rd_valid` = 0 next cycle, `count` = 1.
  - `ovf_clr` in the same cycle as a drop -> `overflow` = 1.
- Reset mid-operation: with 5 bytes stored and `rx_done` held high, assert `rst` for 2 cycles -> immediately `count` = 0, `empty` = 1, `rd_valid` = 0, `rd_data` = 8'h00. After release, no write occurs until `rx_done` falls and rises again.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : circular receive buffer capturing one byte per rx_done rise,
//                with registered read handshake and sticky overflow flag.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int                    C_DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   C_FULL_CNT = (DEPTH_LOG2+1)'(C_DEPTH);
   localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   C_CNT_ONE  = (DEPTH_LOG2+1)'(1);

   logic [7:0]            r_mem [C_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_rx_done_q;

   logic w_wr;
   logic w_rd_acc;
   logic w_wr_acc;
   logic w_drop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == C_FULL_CNT);
   assign count    = r_count;

   // Reads are judged against the current state, so a read of an empty FIFO
   // never sees a byte written in the same cycle.
   assign w_wr     = rx_done & ~r_rx_done_q;
   assign w_rd_acc = rd_en & ~empty;
   assign w_wr_acc = w_wr & (~full | w_rd_acc);
   assign w_drop   = w_wr & full & ~w_rd_acc;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   // rx_done_q resets high so a level held through reset release is not a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_done_q <= 1'b1;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         rd_data     <= 8'h00;
         rd_valid    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         r_rx_done_q <= rx_done;
         rd_valid    <= w_rd_acc;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_rd_acc) begin
            rd_data  <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + C_CNT_ONE;
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - C_CNT_ONE;
         end
         if (w_drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
